// File: rtl/keypad_cmd_fifo_driver.sv
// ---------------------------------------------------------------------------
// keypad_cmd_fifo_driver
//
// Purpose:
//   Sits between the keypad scanner and the editor/executor. In EDIT mode
//   raw key codes are decoded into editor commands (symbol, cursor move,
//   backspace, clear memory). In EXE mode raw codes pass through as symbols.
//   Every produced command goes into a DEPTH-entry first-word-fall-through
//   FIFO with a valid/ready output handshake, so keystroke bursts survive a
//   busy consumer.
//
//   Clear memory takes two presses of 'f': the first arms, the second
//   pushes the clear command. Any other accepted EDIT key disarms.
//
//   When the FIFO is full and a key would push, HOLD_ON_FULL selects
//   whether the key is left with the keypad (1) or consumed and dropped with
//   the sticky overflow flag raised (0).
//
// Ports:
//   working_clock   sole clock, rising edge
//   reset           asynchronous active-low reset
//   to_mode         requested mode (0 = EDIT, 1 = EXE)
//   change_mode     mode change request, sampled every cycle
//   key_available   keypad holds a valid key
//   key             raw key code
//   pull_key        registered one-cycle pulse consuming the key
//   out_valid       FIFO head is valid
//   out_ready       consumer takes the head this cycle
//   out_cmd_mode    0 symbol, 1 cursor, 2 backspace, 3 clear memory
//   out_symbol      symbol value (cmd_mode 0)
//   out_cursor_dir  1 right / 0 left (cmd_mode 1)
//   state           0 INIT, 1 EDIT, 2 EXE
//   fifo_count      occupied FIFO entries
//   overflow        sticky "key dropped" flag
//   clear_overflow  clears overflow (a simultaneous drop wins)
// ---------------------------------------------------------------------------
module keypad_cmd_fifo_driver #(
    parameter int KEY_W        = 4,
    parameter int SYM_W        = 4,
    parameter int DEPTH        = 4,
    parameter int HOLD_ON_FULL = 1
) (
    input  logic                         working_clock,
    input  logic                         reset,
    input  logic                         to_mode,
    input  logic                         change_mode,
    input  logic                         key_available,
    input  logic [KEY_W-1:0]             key,
    output logic                         pull_key,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:0]                   out_cmd_mode,
    output logic [SYM_W-1:0]             out_symbol,
    output logic                         out_cursor_dir,
    output logic [1:0]                   state,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow,
    input  logic                         clear_overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    // Entry layout: {cmd_mode[1:0], cursor_dir, symbol[SYM_W-1:0]}
    localparam int ENT_W = SYM_W + 3;

    localparam logic [CNT_W-1:0] FULL_COUNT   = CNT_W'(DEPTH);
    localparam logic             DROP_ON_FULL = (HOLD_ON_FULL == 0);

    localparam logic [1:0] CMD_SYMBOL    = 2'd0;
    localparam logic [1:0] CMD_CURSOR    = 2'd1;
    localparam logic [1:0] CMD_BACKSPACE = 2'd2;
    localparam logic [1:0] CMD_CLEAR     = 2'd3;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_EDIT = 2'd1,
        ST_EXE  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Registers and their next values
    // -----------------------------------------------------------------------
    state_t             state_reg;
    state_t             state_next;
    logic               mode_switch;

    logic               arm_reg;
    logic               arm_next;
    logic               pull_key_reg;
    logic               overflow_reg;

    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic [CNT_W-1:0]   remain;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_next;

    logic [ENT_W-1:0]   mem [DEPTH];
    logic [ENT_W-1:0]   head_reg;

    // -----------------------------------------------------------------------
    // Key decode signals
    // -----------------------------------------------------------------------
    logic               key_high_zero;
    logic [3:0]         key_lo;
    logic               key_is_f;

    logic               dec_push;
    logic [1:0]         dec_cmd;
    logic [SYM_W-1:0]   dec_sym;
    logic               dec_dir;
    logic [ENT_W-1:0]   push_entry;

    logic               in_mode;
    logic               space;
    logic               accept;
    logic               do_push;
    logic               do_drop;
    logic               do_pop;

    // EDIT symbol table for codes 0..a.
    function automatic logic [3:0] edit_symbol(input logic [3:0] code);
        case (code)
            4'h0:    return 4'd10;
            4'h1:    return 4'd5;
            4'h2:    return 4'd6;
            4'h3:    return 4'd11;
            4'h4:    return 4'd3;
            4'h5:    return 4'd2;
            4'h6:    return 4'd7;
            4'h7:    return 4'd4;
            4'h8:    return 4'd1;
            4'h9:    return 4'd8;
            4'ha:    return 4'd9;
            default: return 4'd0;
        endcase
    endfunction

    assign key_lo = key[3:0];

    // Codes at or above 16 only exist for wide keys; in EDIT they discard.
    generate
        if (KEY_W > 4) begin : g_wide_key
            assign key_high_zero = ~|key[KEY_W-1:4];
        end else begin : g_narrow_key
            assign key_high_zero = 1'b1;
        end
    endgenerate

    assign key_is_f = key_high_zero && (key_lo == 4'hf);

    // -----------------------------------------------------------------------
    // Mode FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        mode_switch = 1'b0;
        case (state_reg)
            ST_INIT: begin
                if (change_mode) begin
                    state_next = to_mode ? ST_EXE : ST_EDIT;
                end
            end
            ST_EDIT: begin
                if (change_mode && to_mode) begin
                    state_next  = ST_EXE;
                    mode_switch = 1'b1;
                end
            end
            ST_EXE: begin
                if (change_mode && !to_mode) begin
                    state_next  = ST_EDIT;
                    mode_switch = 1'b1;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Decode the presented key into the entry it would push (if any)
    // -----------------------------------------------------------------------
    always_comb begin
        dec_push = 1'b0;
        dec_cmd  = CMD_SYMBOL;
        dec_sym  = '0;
        dec_dir  = 1'b0;
        if (state_reg == ST_EXE) begin
            dec_push = 1'b1;
            dec_sym  = SYM_W'(key);
        end else if (key_high_zero) begin
            case (key_lo)
                4'hb: begin
                    dec_push = 1'b1;
                    dec_cmd  = CMD_BACKSPACE;
                end
                4'hc: begin
                    // discard: pulled, never pushed
                    dec_push = 1'b0;
                end
                4'hd: begin
                    dec_push = 1'b1;
                    dec_cmd  = CMD_CURSOR;
                    dec_dir  = 1'b1;
                end
                4'he: begin
                    dec_push = 1'b1;
                    dec_cmd  = CMD_CURSOR;
                    dec_dir  = 1'b0;
                end
                4'hf: begin
                    // Only the second press of the pair produces a command.
                    dec_push = arm_reg;
                    dec_cmd  = CMD_CLEAR;
                end
                default: begin
                    dec_push = 1'b1;
                    dec_sym  = SYM_W'(edit_symbol(key_lo));
                end
            endcase
        end
    end

    assign push_entry = {dec_cmd, dec_dir, dec_sym};

    // -----------------------------------------------------------------------
    // Accept / push / pop decisions
    // -----------------------------------------------------------------------
    assign in_mode = (state_reg == ST_EDIT) || (state_reg == ST_EXE);

    // Space is judged on the pre-pop count: a pop this cycle never makes
    // room for a push in the same cycle.
    assign space = (count_reg < FULL_COUNT);

    // The !pull_key_reg term gives the keypad a cycle to retire the key
    // that was just pulled before the next one can be taken.
    assign accept = key_available && in_mode && !change_mode && !pull_key_reg
                    && (space || !dec_push || DROP_ON_FULL);

    assign do_push = accept && dec_push && space;
    assign do_drop = accept && dec_push && !space;
    assign do_pop  = (count_reg != '0) && out_ready;

    // Entries left from the current contents after this cycle's pop.
    assign remain = count_reg - CNT_W'(do_pop);

    always_comb begin
        arm_next = arm_reg;
        if (mode_switch) begin
            arm_next = 1'b0;
        end else if (accept && (state_reg == ST_EDIT)) begin
            // f toggles the arm (arm or fire-and-disarm); anything else disarms.
            arm_next = key_is_f ? !arm_reg : 1'b0;
        end
    end

    always_comb begin
        count_next  = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        rd_ptr_next = rd_ptr_reg + PTR_W'(do_pop);
        wr_ptr_next = wr_ptr_reg + PTR_W'(do_push);
        if (mode_switch) begin
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage (no reset; contents are qualified by count_reg)
    // -----------------------------------------------------------------------
    always_ff @(posedge working_clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    // -----------------------------------------------------------------------
    // Control state, flags and the registered head
    // -----------------------------------------------------------------------
    always_ff @(posedge working_clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_INIT;
            arm_reg      <= 1'b0;
            pull_key_reg <= 1'b0;
            overflow_reg <= 1'b0;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            head_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            arm_reg      <= arm_next;
            pull_key_reg <= accept;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;

            if (do_drop) begin
                overflow_reg <= 1'b1;
            end else if (clear_overflow) begin
                overflow_reg <= 1'b0;
            end

            // Head follows the next occupied entry. If nothing older remains
            // the new head is the entry being written this edge, so bypass
            // the array. When the FIFO goes empty the head keeps its value.
            if (count_next != '0) begin
                if (remain == '0) begin
                    head_reg <= push_entry;
                end else begin
                    head_reg <= mem[rd_ptr_next];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign pull_key       = pull_key_reg;
    assign out_valid      = (count_reg != '0);
    assign out_cmd_mode   = head_reg[ENT_W-1 -: 2];
    assign out_cursor_dir = head_reg[SYM_W];
    assign out_symbol     = head_reg[SYM_W-1:0];
    assign state          = state_reg;
    assign fifo_count     = count_reg;
    assign overflow       = overflow_reg;

endmodule

// File: tb/tb_keypad_cmd_fifo_driver.sv
// ---------------------------------------------------------------------------
// tb_keypad_cmd_fifo_driver
//
// Two instances share all inputs: dut_h holds keys on a full FIFO,
// dut_d drops them and raises overflow. "sel" picks which one the
// scenario tasks observe. Each task starts from a fresh reset.
// ---------------------------------------------------------------------------
module tb_keypad_cmd_fifo_driver;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       to_mode;
    logic       change_mode;
    logic       key_available;
    logic [3:0] key;
    logic       out_ready;
    logic       clear_overflow;

    logic       h_pull, h_valid, h_dir, h_ovf;
    logic [1:0] h_cm, h_st;
    logic [3:0] h_sym;
    logic [2:0] h_cnt;
    logic       d_pull, d_valid, d_dir, d_ovf;
    logic [1:0] d_cm, d_st;
    logic [3:0] d_sym;
    logic [2:0] d_cnt;

    keypad_cmd_fifo_driver #(.KEY_W(4), .SYM_W(4), .DEPTH(4), .HOLD_ON_FULL(1)) dut_h (
        .working_clock(clk), .reset(rst_n), .to_mode(to_mode), .change_mode(change_mode),
        .key_available(key_available), .key(key), .pull_key(h_pull), .out_valid(h_valid),
        .out_ready(out_ready), .out_cmd_mode(h_cm), .out_symbol(h_sym), .out_cursor_dir(h_dir),
        .state(h_st), .fifo_count(h_cnt), .overflow(h_ovf), .clear_overflow(clear_overflow)
    );

    keypad_cmd_fifo_driver #(.KEY_W(4), .SYM_W(4), .DEPTH(4), .HOLD_ON_FULL(0)) dut_d (
        .working_clock(clk), .reset(rst_n), .to_mode(to_mode), .change_mode(change_mode),
        .key_available(key_available), .key(key), .pull_key(d_pull), .out_valid(d_valid),
        .out_ready(out_ready), .out_cmd_mode(d_cm), .out_symbol(d_sym), .out_cursor_dir(d_dir),
        .state(d_st), .fifo_count(d_cnt), .overflow(d_ovf), .clear_overflow(clear_overflow)
    );

    bit         sel;
    logic       pull, valid, dir, ovf;
    logic [1:0] cm, st;
    logic [3:0] sym;
    logic [2:0] cnt;
    assign pull  = sel ? d_pull  : h_pull;
    assign valid = sel ? d_valid : h_valid;
    assign dir   = sel ? d_dir   : h_dir;
    assign ovf   = sel ? d_ovf   : h_ovf;
    assign cm    = sel ? d_cm    : h_cm;
    assign st    = sel ? d_st    : h_st;
    assign sym   = sel ? d_sym   : h_sym;
    assign cnt   = sel ? d_cnt   : h_cnt;

    int checks = 0;
    int errors = 0;

    // Reference: EDIT symbol table indexed by key code 0..10.
    int sym_tab [11] = '{10, 5, 6, 11, 3, 2, 7, 4, 1, 8, 9};
    bit m_arm;

    logic [3:0] edit_keys [4] = '{4'h8, 4'h5, 4'hd, 4'hb};

    // Entry encoding in the model: cmd*256 + dir*16 + symbol.
    function automatic void model_key(input bit exe, input int k, output bit push, output int ent);
        push = 1'b1;
        ent  = 0;
        if (exe) begin
            ent = k;
            return;
        end
        if (k != 15) m_arm = 1'b0;
        if (k <= 10)       ent = sym_tab[k];
        else if (k == 11)  ent = 2 * 256;
        else if (k == 12)  push = 1'b0;
        else if (k == 13)  ent = 256 + 16;
        else if (k == 14)  ent = 256;
        else if (m_arm) begin
            ent   = 3 * 256;
            m_arm = 1'b0;
        end else begin
            push  = 1'b0;
            m_arm = 1'b1;
        end
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; to_mode = 1'b0; change_mode = 1'b0; key_available = 1'b0;
        key = 4'h0; out_ready = 1'b0; clear_overflow = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic go_mode(input bit m);
        change_mode = 1'b1;
        to_mode     = m;
        tick();
        change_mode = 1'b0;
    endtask

    // Present a key and wait (bounded) for its pull. On timeout the key is
    // left presented for the caller to handle.
    task automatic send_key(input logic [3:0] k, input int max_cyc, output bit got, output int lat);
        key = k; key_available = 1'b1; got = 1'b0; lat = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            tick();
            if (pull) begin
                got = 1'b1; lat = i; key_available = 1'b0;
                break;
            end
        end
        $display("key %h got=%0d after %0d cycles", k, got, lat);
    endtask

    task automatic pop_one(output logic [1:0] c, output logic [3:0] s, output logic d);
        c = cm; s = sym; d = dir;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("pop cmd=%0d sym=%0d dir=%0d", c, s, d);
    endtask

    task automatic test_reset();
        bit got; int lat; bit saw;
        sel = 1'b0;
        do_reset();
        checks++; if (st !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", st); end
        checks++; if (cnt !== 3'd0 || valid !== 1'b0) begin errors++; $display("FAIL reset_fifo: count %0d valid %0d expected 0 0", cnt, valid); end
        checks++; if (pull !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_flags: pull %0d ovf %0d expected 0 0", pull, ovf); end
        checks++; if ({cm, sym, dir} !== 7'd0) begin errors++; $display("FAIL reset_head: got %0h expected 0", {cm, sym, dir}); end
        go_mode(1'b0);
        for (int i = 1; i <= 3; i++) begin
            send_key(4'(i), 4, got, lat);
            tick();
        end
        checks++; if (cnt !== 3'd3) begin errors++; $display("FAIL burst_count: got %0d expected 3", cnt); end
        key = 4'h4; key_available = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (cnt !== 3'd0 || valid !== 1'b0) begin errors++; $display("FAIL midburst_flush: count %0d valid %0d expected 0 0", cnt, valid); end
        checks++; if (st !== 2'd0 || pull !== 1'b0) begin errors++; $display("FAIL midburst_state: state %0d pull %0d expected 0 0", st, pull); end
        tick();
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pull) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0 || st !== 2'd0) begin errors++; $display("FAIL init_ignores_keys: pull_seen %0d state %0d expected 0 0", saw, st); end
        change_mode = 1'b1; to_mode = 1'b0;
        tick();
        change_mode = 1'b0;
        checks++; if (st !== 2'd1 || pull !== 1'b0) begin errors++; $display("FAIL init_to_edit: state %0d pull %0d expected 1 0", st, pull); end
        tick();
        checks++; if (pull !== 1'b1) begin errors++; $display("FAIL edit_first_accept: pull %0d expected 1", pull); end
        key_available = 1'b0;
        tick();
    endtask

    task automatic test_edit_decode();
        bit got; int lat; logic [1:0] c; logic [3:0] s; logic d;
        int exp_cm [4] = '{0, 0, 1, 2};
        int exp_sym [4] = '{1, 2, 0, 0};
        sel = 1'b0;
        do_reset();
        go_mode(1'b0);
        for (int i = 0; i < 4; i++) begin
            send_key(edit_keys[i], 4, got, lat);
            checks++; if (!got || lat != 1) begin errors++; $display("FAIL decode_pull_latency: got %0d lat %0d expected 1 1", got, lat); end
            tick();
            checks++; if (pull !== 1'b0) begin errors++; $display("FAIL decode_pull_width: pull %0d expected 0", pull); end
        end
        checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL decode_count: got %0d expected 4", cnt); end
        for (int i = 0; i < 4; i++) begin
            pop_one(c, s, d);
            checks++; if (c !== 2'(exp_cm[i])) begin errors++; $display("FAIL decode_cmd: got %0d expected %0d", c, exp_cm[i]); end
            if (exp_cm[i] == 0) begin
                checks++; if (s !== 4'(exp_sym[i])) begin errors++; $display("FAIL decode_sym: got %0d expected %0d", s, exp_sym[i]); end
            end
            if (exp_cm[i] == 1) begin
                checks++; if (d !== 1'b1) begin errors++; $display("FAIL decode_dir: got %0d expected 1", d); end
            end
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL decode_drained: valid %0d expected 0", valid); end
    endtask

    task automatic test_clear_seq();
        bit got; int lat; logic [1:0] c; logic [3:0] s; logic d;
        sel = 1'b0;
        do_reset();
        go_mode(1'b0);
        send_key(4'hf, 4, got, lat); tick();
        checks++; if (cnt !== 3'd0 || !got) begin errors++; $display("FAIL arm_no_push: count %0d pulled %0d expected 0 1", cnt, got); end
        send_key(4'hf, 4, got, lat); tick();
        checks++; if (cnt !== 3'd1 || cm !== 2'd3) begin errors++; $display("FAIL clear_push: count %0d cmd %0d expected 1 3", cnt, cm); end
        pop_one(c, s, d);
        send_key(4'hf, 4, got, lat); tick();
        send_key(4'h8, 4, got, lat); tick();
        send_key(4'hf, 4, got, lat); tick();
        checks++; if (cnt !== 3'd1 || cm !== 2'd0 || sym !== 4'd1) begin errors++; $display("FAIL disarm: count %0d cmd %0d sym %0d expected 1 0 1", cnt, cm, sym); end
        send_key(4'hf, 4, got, lat); tick();
        checks++; if (cnt !== 3'd2) begin errors++; $display("FAIL rearmed: count %0d expected 2", cnt); end
        pop_one(c, s, d);
        pop_one(c, s, d);
        checks++; if (c !== 2'd3) begin errors++; $display("FAIL rearmed_clear: cmd %0d expected 3", c); end
    endtask

    task automatic test_hold_full();
        bit got; int lat; logic [1:0] c; logic [3:0] s; logic d;
        int exp_sym [4] = '{5, 6, 11, 3};
        sel = 1'b0;
        do_reset();
        go_mode(1'b0);
        for (int i = 0; i < 4; i++) begin
            send_key(4'(i), 4, got, lat); tick();
        end
        checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL hold_fill: count %0d expected 4", cnt); end
        send_key(4'h4, 6, got, lat);
        checks++; if (got !== 1'b0 || cnt !== 3'd4) begin errors++; $display("FAIL hold_blocked: pulled %0d count %0d expected 0 4", got, cnt); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (pull !== 1'b0 || cnt !== 3'd3) begin errors++; $display("FAIL hold_prepop: pull %0d count %0d expected 0 3", pull, cnt); end
        got = 1'b0; lat = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (pull) begin got = 1'b1; lat = i; break; end
        end
        key_available = 1'b0;
        checks++; if (!got || lat != 1 || cnt !== 3'd4) begin errors++; $display("FAIL hold_release: pulled %0d lat %0d count %0d expected 1 1 4", got, lat, cnt); end
        tick();
        for (int i = 0; i < 4; i++) begin
            pop_one(c, s, d);
            checks++; if (s !== 4'(exp_sym[i])) begin errors++; $display("FAIL hold_order: sym %0d expected %0d", s, exp_sym[i]); end
        end
    endtask

    task automatic test_overflow();
        bit got; int lat; logic [1:0] c; logic [3:0] s; logic d;
        sel = 1'b1;
        do_reset();
        go_mode(1'b0);
        for (int i = 0; i < 4; i++) begin
            send_key(4'(i), 4, got, lat); tick();
        end
        send_key(4'h3, 4, got, lat);
        checks++; if (!got || lat != 1) begin errors++; $display("FAIL drop_pull: pulled %0d lat %0d expected 1 1", got, lat); end
        checks++; if (cnt !== 3'd4 || ovf !== 1'b1) begin errors++; $display("FAIL drop_flag: count %0d ovf %0d expected 4 1", cnt, ovf); end
        tick();
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: ovf %0d expected 0", ovf); end
        key = 4'h3; key_available = 1'b1; clear_overflow = 1'b1;
        tick();
        key_available = 1'b0;
        checks++; if (pull !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL set_wins: pull %0d ovf %0d expected 1 1", pull, ovf); end
        tick();
        clear_overflow = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear2: ovf %0d expected 0", ovf); end
        send_key(4'hf, 4, got, lat); tick();
        checks++; if (!got || cnt !== 3'd4 || ovf !== 1'b0) begin errors++; $display("FAIL full_arm: pulled %0d count %0d ovf %0d expected 1 4 0", got, cnt, ovf); end
        send_key(4'hf, 4, got, lat); tick();
        checks++; if (cnt !== 3'd4 || ovf !== 1'b1) begin errors++; $display("FAIL full_clear_drop: count %0d ovf %0d expected 4 1", cnt, ovf); end
        pop_one(c, s, d);
        checks++; if (s !== 4'd10 || cnt !== 3'd3) begin errors++; $display("FAIL drop_head: sym %0d count %0d expected 10 3", s, cnt); end
        send_key(4'hf, 4, got, lat); tick();
        checks++; if (cnt !== 3'd3) begin errors++; $display("FAIL arm_after_drop: count %0d expected 3", cnt); end
    endtask

    task automatic test_exe_flush();
        bit got; int lat;
        sel = 1'b0;
        do_reset();
        go_mode(1'b1);
        checks++; if (st !== 2'd2) begin errors++; $display("FAIL exe_state: state %0d expected 2", st); end
        send_key(4'hc, 4, got, lat); tick();
        checks++; if (cm !== 2'd0 || sym !== 4'hc || valid !== 1'b1) begin errors++; $display("FAIL exe_raw: cmd %0d sym %0d valid %0d expected 0 12 1", cm, sym, valid); end
        send_key(4'h7, 4, got, lat); tick();
        change_mode = 1'b1; to_mode = 1'b1;
        tick();
        change_mode = 1'b0;
        checks++; if (cnt !== 3'd2 || st !== 2'd2) begin errors++; $display("FAIL same_mode: count %0d state %0d expected 2 2", cnt, st); end
        key = 4'h5; key_available = 1'b1;
        change_mode = 1'b1; to_mode = 1'b0;
        tick();
        change_mode = 1'b0;
        checks++; if (st !== 2'd1 || cnt !== 3'd0 || valid !== 1'b0) begin errors++; $display("FAIL flush: state %0d count %0d valid %0d expected 1 0 0", st, cnt, valid); end
        checks++; if (pull !== 1'b0 || sym !== 4'hc) begin errors++; $display("FAIL flush_hold: pull %0d sym %0d expected 0 12", pull, sym); end
        tick();
        key_available = 1'b0;
        checks++; if (pull !== 1'b1 || cnt !== 3'd1 || sym !== 4'd2) begin errors++; $display("FAIL post_switch: pull %0d count %0d sym %0d expected 1 1 2", pull, cnt, sym); end
        tick();
    endtask

    task automatic test_back_to_back();
        int pulls; bit prev; bit adj; int maxc;
        sel = 1'b0;
        do_reset();
        go_mode(1'b1);
        out_ready = 1'b1; key = 4'h5; key_available = 1'b1;
        pulls = 0; prev = 1'b0; adj = 1'b0; maxc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pull) pulls++;
            if (pull && prev) adj = 1'b1;
            prev = pull;
            if (int'(cnt) > maxc) maxc = int'(cnt);
        end
        key_available = 1'b0; out_ready = 1'b0;
        tick();
        checks++; if (pulls != 10 || adj) begin errors++; $display("FAIL b2b_rate: pulls %0d adjacent %0d expected 10 0", pulls, adj); end
        checks++; if (maxc != 1) begin errors++; $display("FAIL b2b_depth: max count %0d expected 1", maxc); end
    endtask

    task automatic test_random(input bit exe, input int cycles);
        int q[$]; int held; bit push; int ent; int ecm; logic [3:0] pk;
        sel = 1'b0;
        do_reset();
        go_mode(exe);
        m_arm = 1'b0; held = 0; pk = 4'h0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (key_available && pull) begin
                model_key(exe, int'(pk), push, ent);
                if (push) q.push_back(ent);
                $display("rand key %h push=%0d depth=%0d", pk, push, q.size());
                key_available = 1'b0;
            end
            checks++; if (int'(cnt) != q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", cnt, q.size()); end
            checks++; if (valid !== (q.size() != 0)) begin errors++; $display("FAIL rand_valid: got %0d expected %0d", valid, q.size() != 0); end
            if (q.size() != 0) begin
                ecm = q[0] / 256;
                checks++; if (int'(cm) != ecm) begin errors++; $display("FAIL rand_cmd: got %0d expected %0d", cm, ecm); end
                if (ecm == 0) begin
                    checks++; if (int'(sym) != q[0] % 16) begin errors++; $display("FAIL rand_sym: got %0d expected %0d", sym, q[0] % 16); end
                end
                if (ecm == 1) begin
                    checks++; if (int'(dir) != (q[0] / 16) % 2) begin errors++; $display("FAIL rand_dir: got %0d expected %0d", dir, (q[0] / 16) % 2); end
                end
            end
            out_ready = ($urandom_range(0, 1) == 1);
            if (out_ready && q.size() != 0) void'(q.pop_front());
            if (key_available) begin
                held++;
                if (held > 40) begin
                    checks++; errors++;
                    $display("FAIL rand_pull_timeout: key %h held %0d cycles, expected a pull", pk, held);
                    key_available = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                pk = 4'($urandom_range(0, 15));
                key = pk; key_available = 1'b1; held = 0;
            end
        end
        key_available = 1'b0; out_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_edit_decode();
        test_clear_seq();
        test_hold_full();
        test_overflow();
        test_exe_flush();
        test_back_to_back();
        test_random(1'b0, 300);
        test_random(1'b1, 300);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/keypad_cmd_fifo_driver.md
Name: keypad_cmd_fifo_driver

Overview:
- Parametrised successor to the brainfuck keypad driver.
- Sits between the keypad scanner and the editor/executor. It decodes raw key codes into editor commands in EDIT mode, or passes raw symbols through in EXE mode.
- Decoded commands are buffered in a DEPTH-entry first-word-fall-through FIFO with a valid/ready handshake, so bursts of keystrokes are not lost while the consumer is busy.
- Adds two behaviours: a two-press clear-memory sequence and an overflow policy.

Parameters:
- KEY_W, 4: raw key code width; must be ≥4.
- SYM_W, 4: output symbol width; must be ≥ KEY_W.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- HOLD_ON_FULL, 1:
  - 1: key left unpulled while the FIFO is full.
  - 0: key pulled, dropped, and overflow set.

Ports:
- working_clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- to_mode  in  1  target mode: 0 = EDIT, 1 = EXE.
- change_mode  in  1  mode-change request, sampled each cycle.
- key_available  in  1  keypad holds a valid key.
- key  in  KEY_W  raw key code.
- pull_key  out  1  one-cycle registered pulse consuming the key.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_cmd_mode  out  2  0 = symbol, 1 = cursor, 2 = backspace, 3 = clear memory.
- out_symbol  out  SYM_W  symbol; valid when cmd_mode = 0.
- out_cursor_dir  out  1  1 = right, 0 = left; valid when cmd_mode = 1.
- state  out  2  0 = INIT, 1 = EDIT, 2 = EXE.
- fifo_count  out  $clog2(DEPTH+1)  occupied entries.
- overflow  out  1  sticky drop flag.
- clear_overflow  in  1  clears overflow.

Behaviour:
- Reset (asynchronous, reset = 0):
  - state = INIT, FIFO empty, fifo_count = 0.
  - pull_key = 0, out_valid = 0, overflow = 0, clear-arm = 0.
  - out_cmd_mode = 0, out_symbol = 0, out_cursor_dir = 0.
  - Reset mid-burst discards all FIFO contents.
- State transitions:
  - INIT: change_mode → EDIT if to_mode = 0, else EXE. Keys are ignored in INIT; pull_key stays 0.
  - EDIT/EXE: change_mode with to_mode ≠ current mode → switch at the next edge, flush the FIFO, clear arm.
  - change_mode to the current mode: no effect.
  - No key is accepted in a cycle where change_mode = 1.
- Accept condition: key_available & state ∈ {EDIT, EXE} & !change_mode & !pull_key & (space or discard).
  - space = fifo_count < DEPTH.
  - pull_key is asserted the cycle after accept, so at most one key is accepted per 2 cycles.
- EXE decode: push {cmd_mode 0, symbol = key zero-extended to SYM_W}. All codes are pushed.
- EDIT decode (codes ≥ 16 are discard):
  - Symbols: 0→10, 1→5, 2→6, 3→11, 4→3, 5→2, 6→7, 7→4, 8→1, 9→8, a→9.
  - b: backspace (cmd 2).
  - d: cursor right (cmd 1, dir 1).
  - e: cursor left (cmd 1, dir 0).
  - c: discard.
  - f: clear sequence.
    - f with arm = 0: sets arm, no push.
    - f with arm = 1: pushes clear (cmd 3), clears arm.
    - Any other accepted key clears arm and is processed normally.
- Discards and arming f: always pulled, never pushed, and need no FIFO space.
- FIFO full with a pushing key:
  - HOLD_ON_FULL = 1: key not accepted and remains; no pull_key.
  - HOLD_ON_FULL = 0: key accepted and pulled, not pushed; overflow set. Arm still updates.
- Pop and full interaction: a pop in the same cycle does not unblock a full FIFO; the push is evaluated against the pre-pop count. Push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged.
- FIFO output: first-word-fall-through.
  - out_valid = fifo_count ≠ 0.
  - Outputs show the head entry; pop on out_valid & out_ready.
  - Push→out_valid latency: 1 cycle.
  - Pointers wrap modulo DEPTH.
  - Output fields hold the last head value when empty.
- Overflow flag:
  - Cleared by clear_overflow.
  - If set and clear_overflow occur in the same cycle, set wins.

Test Plan:
- reset low mid-burst with 3 entries → fifo_count = 0, out_valid = 0, state = INIT; keys ignored until change_mode = 1, to_mode = 0.
- EDIT; keys 8, 5, d, b with out_ready = 0 → FIFO holds {0,1}, {0,2}, {1,dir 1}, {2}; pull_key pulses 4 times, each pulse one cycle after its accept.
- EDIT; keys f, f → single clear entry {3}. Keys f, 8, f → {0,1} only, arm = 1 after the last f.
- DEPTH = 4, HOLD_ON_FULL = 1; 5 symbol keys with out_ready = 0 → 4th fills the FIFO, 5th key held with no pull_key; raising out_ready pops one entry, then the 5th is accepted.
- HOLD_ON_FULL = 0, full FIFO; key 3 → pull_key pulses, fifo_count stays 4, overflow = 1; clear_overflow → overflow = 0.
- EXE; key c → {0, 0xc}. change_mode to EDIT with 2 entries queued → FIFO flushed, state = EDIT; a key held that cycle is accepted the following cycle.
